// File: rtl/stsystem_arbiter.sv
// Four-requester round-robin arbiter in front of a single byte transmitter.
// Optional frame watchdog enabled by defining STSYSTEM_ARB_WATCHDOG_EN.
module stsystem_arbiter #(
   parameter int unsigned TO_CYCLES = 1000,
   parameter int unsigned TO_W      = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] data,
   input  logic        rts,
   output logic        send,
   output logic [7:0]  d,
   output logic [3:0]  grant,
   output logic [3:0]  done,
   output logic        err
);

   typedef enum logic [2:0] {StIdle, StSend, StBusy, StDone, StAbort} state_e;

   state_e     state_q;
   logic [1:0] ptr_q;
   logic [1:0] owner_q;
   logic [1:0] win;
   logic       timeout;

`ifdef STSYSTEM_ARB_WATCHDOG_EN
   logic [TO_W-1:0] cnt_q;

   // Fires on the cycle whose increment would make the count reach TO_CYCLES.
   assign timeout = (state_q == StSend || state_q == StBusy) &&
                    (cnt_q == TO_W'(TO_CYCLES - 1));
`else
   logic unused_cfg;

   assign timeout    = 1'b0;
   assign err        = 1'b0;
   assign unused_cfg = (TO_CYCLES >= (32'd1 << TO_W));
`endif

   // Search ptr+1, ptr+2, ptr+3, ptr; descending loop lets the nearest requester win.
   always_comb begin
      win = ptr_q + 2'd1;
      for (int k = 4; k >= 1; k--) begin
         if (req[2'(ptr_q + 2'(k))]) begin
            win = 2'(ptr_q + 2'(k));
         end
      end
   end

   assign send = (state_q == StSend);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         ptr_q   <= 2'd3;
         owner_q <= 2'd0;
         d       <= 8'h00;
         grant   <= 4'b0000;
         done    <= 4'b0000;
`ifdef STSYSTEM_ARB_WATCHDOG_EN
         cnt_q   <= '0;
         err     <= 1'b0;
`endif
      end else begin
         done <= 4'b0000;
         unique case (state_q)
            StIdle: begin
               if (|req) begin
                  owner_q <= win;
                  grant   <= 4'b0001 << win;
                  d       <= data[{win, 3'b000} +: 8];
                  state_q <= StSend;
               end
            end
            StSend: begin
               if (timeout) begin
                  grant   <= 4'b0000;
                  ptr_q   <= owner_q;
                  state_q <= StAbort;
               end else if (rts) begin
                  state_q <= StBusy;
               end
            end
            StBusy: begin
               if (timeout) begin
                  grant   <= 4'b0000;
                  ptr_q   <= owner_q;
                  state_q <= StAbort;
               end else if (!rts) begin
                  done    <= grant;
                  grant   <= 4'b0000;
                  ptr_q   <= owner_q;
                  state_q <= StDone;
               end
            end
            StDone:  state_q <= StIdle;
            StAbort: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
`ifdef STSYSTEM_ARB_WATCHDOG_EN
         cnt_q <= (state_q == StSend || state_q == StBusy) ? cnt_q + 1'b1 : '0;
         err   <= timeout;
`endif
      end
   end

endmodule

// File: tb/tb_stsystem_arbiter.sv
// Self-checking bench for stsystem_arbiter: directed scenarios plus randomized frames
// checked against a round-robin reference model.
module tb_stsystem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = 4'b0;
   logic [31:0] data = 32'h0;
   logic        rts = 1'b0;
   logic        send;
   logic [7:0]  d;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        err;

   int checks = 0;
   int passed = 0;
   int model_ptr = 3;
   logic [7:0] model_d = 8'h00;

   stsystem_arbiter #(
      .TO_CYCLES(20),
      .TO_W(10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .data(data),
      .rts(rts),
      .send(send),
      .d(d),
      .grant(grant),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 1; k <= 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [7:0] lane(input logic [31:0] v, input int i);
      return v[8*i +: 8];
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req  = 4'b0;
      data = 32'h0;
      rts  = 1'b0;
      rst  = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      model_ptr = 3;
      model_d   = 8'h00;
   endtask

   // One complete frame: arbitration, rts handshake after dly cycles, rts high for len cycles.
   task automatic run_frame(input logic [3:0] r, input logic [31:0] dat, input int dly,
                            input int len, input bit drop);
      int         w;
      int         lat;
      int         sends;
      int         pulses;
      logic [3:0] exp_g;
      w     = rr_pick(r, model_ptr);
      exp_g = 4'b0001 << w;
      req   = r;
      data  = dat;
      lat   = 0;
      do begin
         tick();
         lat++;
      end while (grant === 4'b0 && lat < 8);
      checks++;
      if (lat !== 1 || grant !== exp_g || send !== 1'b1)
         $display("FAIL grant: got %b send=%b after %0d cycles, want %b send=1 after 1",
                  grant, send, lat, exp_g);
      else passed++;
      checks++;
      if (d !== lane(dat, w)) $display("FAIL d_capture: got %h, want %h", d, lane(dat, w));
      else passed++;
      model_d = lane(dat, w);
      // Post-sample changes must not disturb d or grant.
      data = ~dat;
      if (drop) req = 4'b0;
      sends = 0;
      repeat (dly) begin
         if (send === 1'b1) sends++;
         tick();
      end
      if (send === 1'b1) sends++;
      rts = 1'b1;
      tick();
      checks++;
      if (sends !== dly + 1 || send !== 1'b0)
         $display("FAIL send_len: got %0d cycles (send now %b), want %0d cycles then 0",
                  sends, send, dly + 1);
      else passed++;
      pulses = 0;
      repeat (len) begin
         if (done !== 4'b0) pulses++;
         tick();
      end
      rts = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (done === 4'b0 && lat < 8);
      checks++;
      if (lat !== 1 || done !== exp_g || grant !== 4'b0 || pulses !== 0)
         $display("FAIL done: got done=%b grant=%b lat=%0d early=%0d, want done=%b grant=0 lat=1",
                  done, grant, lat, pulses, exp_g);
      else passed++;
      model_ptr = w;
      tick();
      checks++;
      if (done !== 4'b0 || grant !== 4'b0 || d !== model_d)
         $display("FAIL idle_gap: got done=%b grant=%b d=%h, want 0 0 %h",
                  done, grant, d, model_d);
      else passed++;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (send !== 1'b0 || d !== 8'h00 || grant !== 4'b0 || done !== 4'b0 || err !== 1'b0)
         $display("FAIL reset: got send=%b d=%h grant=%b done=%b err=%b, want all zero",
                  send, d, grant, done, err);
      else passed++;
   endtask

   task automatic test_basic();
      run_frame(4'b0001, {$urandom_range(0, 16777215), 8'hA5} , 1, 10, 1'b0);
      req = 4'b0;
   endtask

   task automatic test_rts_idle();
      int bad;
      req = 4'b0;
      bad = 0;
      rts = 1'b1;
      repeat (3) begin
         tick();
         if (grant !== 4'b0 || send !== 1'b0 || done !== 4'b0) bad++;
      end
      rts = 1'b0;
      tick();
      checks++;
      if (bad !== 0 || d !== model_d)
         $display("FAIL rts_idle: got %0d bad cycles d=%h, want 0 bad d=%h", bad, d, model_d);
      else passed++;
   endtask

   task automatic test_fairness();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         run_frame(4'b1111, 32'h44332211, i % 3, 2, 1'b0);
         checks++;
         if (model_d !== lane(32'h44332211, i % 4))
            $display("FAIL rotation: got lane %h, want %h", model_d, lane(32'h44332211, i % 4));
         else passed++;
      end
      req = 4'b0;
   endtask

   task automatic test_drop();
      run_frame(4'b0100, $urandom, 2, 3, 1'b1);
      req = 4'b0;
   endtask

   task automatic test_reset_mid_frame();
      int pulses;
      req  = 4'b1000;
      data = $urandom;
      tick();
      rts = 1'b1;
      repeat (2) tick();
      #2 rst = 1'b0;
      #1;
      checks++;
      if (send !== 1'b0 || d !== 8'h00 || grant !== 4'b0 || done !== 4'b0 || err !== 1'b0)
         $display("FAIL async_reset: got send=%b d=%h grant=%b done=%b err=%b, want all zero",
                  send, d, grant, done, err);
      else passed++;
      req = 4'b0;
      tick();
      rst = 1'b1;
      model_ptr = 3;
      model_d   = 8'h00;
      pulses = 0;
      repeat (2) begin
         tick();
         if (done !== 4'b0) pulses++;
      end
      rts = 1'b0;
      repeat (3) begin
         tick();
         if (done !== 4'b0 || grant !== 4'b0) pulses++;
      end
      checks++;
      if (pulses !== 0) $display("FAIL no_done_after_reset: got %0d events, want 0", pulses);
      else passed++;
      run_frame(4'b0010, $urandom, 0, 2, 1'b0);
      req = 4'b0;
   endtask

   task automatic test_watchdog();
      int sends;
      int err_at;
      do_reset();
      req  = 4'b0001;
      data = $urandom;
      tick();
      sends  = (send === 1'b1) ? 1 : 0;
      err_at = -1;
`ifdef STSYSTEM_ARB_WATCHDOG_EN
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (err === 1'b1) begin
            err_at = i;
            break;
         end
         if (send === 1'b1) sends++;
      end
      checks++;
      if (err_at !== 20 || sends !== 20 || done !== 4'b0 || grant !== 4'b0 || send !== 1'b0)
         $display("FAIL watchdog: got err at %0d send %0d cycles done=%b grant=%b, want 20 20 0 0",
                  err_at, sends, done, grant);
      else passed++;
      model_ptr = 0;
      req = 4'b1111;
      tick();
      checks++;
      if (err !== 1'b0 || done !== 4'b0) $display("FAIL err_pulse: got err=%b done=%b, want 0 0",
                                                  err, done);
      else passed++;
      run_frame(4'b1111, $urandom, 1, 2, 1'b0);
      checks++;
      if (model_ptr !== 1) $display("FAIL after_abort: got winner %0d, want 1", model_ptr);
      else passed++;
      req = 4'b0;
`else
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (send === 1'b1 && err === 1'b0 && done === 4'b0) sends++;
      end
      checks++;
      if (sends !== 101) $display("FAIL no_watchdog: got %0d good cycles, want 101", sends);
      else passed++;
      checks++;
      if (err_at !== -1 || grant !== 4'b0001) $display("FAIL no_watchdog_grant: got %b, want 0001",
                                                        grant);
      else passed++;
      do_reset();
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         run_frame(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3),
                   $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      end
      req = 4'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rts_idle();
      test_fairness();
      test_drop();
      test_reset_mid_frame();
      test_watchdog();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
